// File: rtl/uart_bpm_parser.sv
// uart_bpm_parser: 8N1 UART receiver feeding an ASCII "BPM<digits>" frame parser.
// Emits the decoded rate with a valid strobe, plus overflow, framing and parse
// error strobes. All strobes are single-cycle registered pulses.
module uart_bpm_parser #(
    parameter int CLK_DIV     = 5208,
    parameter int MAX_DIGITS  = 3,
    parameter int OUT_W       = 8,
    parameter int TIMEOUT_CYC = 156240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_rx,
    output logic [OUT_W-1:0] xinlv,
    output logic             xinlv_valid,
    output logic             ovf,
    output logic             frame_err,
    output logic             parse_err,
    output logic [7:0]       rx_byte,
    output logic             rx_byte_valid
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int ACC_W = 14;

    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      OUT_MAX   = 32'((64'd1 << OUT_W) - 64'd1);

    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CH_P = 8'h50;
    localparam logic [7:0] CH_M = 8'h4D;
    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_9 = 8'h39;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, GOT_B, GOT_P, DIGITS} p_state_t;

    // ---------------- UART receiver ----------------
    rx_state_t        rx_state, rx_next;
    logic             sync1, sync2, rx_prev;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             sample;
    logic             rx_s;

    assign rx_s = sync2;

    // RX state register.
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    // RX next-state and sample-point decode.
    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rx_next = rx_state;
        sample  = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_s) rx_next = START;
            end
            START: begin
                if (baud_cnt == HALF_TICK) begin
                    sample  = 1'b1;
                    rx_next = rx_s ? IDLE : DATA;   // line back high: glitch, not a start bit
                end
            end
            DATA: begin
                if (baud_cnt == FULL_TICK) begin
                    sample = 1'b1;
                    if (bit_cnt == 3'd7) rx_next = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == FULL_TICK) begin
                    sample  = 1'b1;
                    rx_next = IDLE;                 // leave mid stop bit to catch a gapless next start
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    // RX datapath: synchroniser, bit timing, shift register and byte strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            rx_prev       <= 1'b1;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            sync1         <= data_rx;
            sync2         <= sync1;
            rx_prev       <= sync2;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
            if (rx_state == IDLE || sample) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + CNT_W'(1);
            if (sample) begin
                case (rx_state)
                    START: bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    STOP: begin
                        if (rx_s) begin
                            rx_byte       <= shift_reg;
                            rx_byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Frame parser ----------------
    p_state_t         p_state, p_next;
    logic [ACC_W-1:0] acc, acc_next, commit_val;
    logic [2:0]       dcnt, dcnt_next;
    logic [TO_W-1:0]  to_cnt;
    logic             commit, perr, timeout, is_digit, ovf_c;

    assign timeout  = (p_state != P_IDLE) && (to_cnt == TO_LAST);
    assign is_digit = (rx_byte >= CH_0) && (rx_byte <= CH_9);
    assign ovf_c    = 32'(commit_val) > OUT_MAX;

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_state <= P_IDLE;
        else        p_state <= p_next;
    end

    // Parser next-state, accumulator update, commit and parse-error decode.
    always_comb begin
        p_next     = p_state;
        acc_next   = acc;
        dcnt_next  = dcnt;
        commit     = 1'b0;
        commit_val = acc;
        perr       = 1'b0;
        if (frame_err) begin
            p_next = P_IDLE;                        // a corrupted byte aborts the frame silently
        end else if (rx_byte_valid) begin
            case (p_state)
                P_IDLE: begin
                    if (rx_byte == CH_B) p_next = GOT_B;
                end
                GOT_B: begin
                    if (rx_byte == CH_P)      p_next = GOT_P;
                    else if (rx_byte != CH_B) begin perr = 1'b1; p_next = P_IDLE; end
                end
                GOT_P: begin
                    if (rx_byte == CH_M) begin
                        p_next    = DIGITS;
                        acc_next  = '0;
                        dcnt_next = '0;
                    end else begin
                        perr   = 1'b1;
                        p_next = (rx_byte == CH_B) ? GOT_B : P_IDLE;
                    end
                end
                DIGITS: begin
                    if (is_digit) begin
                        acc_next   = acc * ACC_W'(10) + ACC_W'(rx_byte - CH_0);
                        dcnt_next  = dcnt + 3'd1;
                        commit_val = acc_next;
                        if (dcnt_next == 3'(MAX_DIGITS)) begin
                            commit = 1'b1;
                            p_next = P_IDLE;
                        end
                    end else begin
                        // A non-digit terminates the number; a 'B' also opens the next frame.
                        if (dcnt != '0) commit = 1'b1;
                        else            perr   = 1'b1;
                        p_next = (rx_byte == CH_B) ? GOT_B : P_IDLE;
                    end
                end
                default: p_next = P_IDLE;
            endcase
        end else if (timeout) begin
            p_next = P_IDLE;
            if (p_state == DIGITS && dcnt != '0) commit = 1'b1;
        end
    end

    // Parser datapath: accumulator, idle timer and registered result strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            dcnt        <= '0;
            to_cnt      <= '0;
            xinlv       <= '0;
            xinlv_valid <= 1'b0;
            ovf         <= 1'b0;
            parse_err   <= 1'b0;
        end else begin
            acc         <= acc_next;
            dcnt        <= dcnt_next;
            xinlv_valid <= commit;
            ovf         <= commit && ovf_c;
            parse_err   <= perr;
            if (rx_byte_valid || p_state == P_IDLE) to_cnt <= '0;
            else                                    to_cnt <= to_cnt + TO_W'(1);
            if (commit) xinlv <= ovf_c ? '1 : OUT_W'(commit_val);
        end
    end

endmodule

// File: tb/tb_uart_bpm_parser.sv
// Testbench for uart_bpm_parser: directed scenarios plus a randomized token
// stream, checked against a character-level reference model with cycle-exact
// commit timing.
module tb_uart_bpm_parser;
    localparam int CLK_DIV     = 16;
    localparam int MAX_DIGITS  = 3;
    localparam int OUT_W       = 8;
    localparam int TIMEOUT_CYC = 3 * 10 * CLK_DIV;
    localparam int OUT_MAX     = (1 << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             data_rx = 1'b1;
    logic [OUT_W-1:0] xinlv;
    logic             xinlv_valid, ovf, frame_err, parse_err, rx_byte_valid;
    logic [7:0]       rx_byte;

    uart_bpm_parser #(
        .CLK_DIV(CLK_DIV), .MAX_DIGITS(MAX_DIGITS), .OUT_W(OUT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_rx(data_rx),
        .xinlv(xinlv), .xinlv_valid(xinlv_valid), .ovf(ovf),
        .frame_err(frame_err), .parse_err(parse_err),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- monitor (sole writer of observed data) ----------------
    int         cyc = 0;
    logic [7:0] got_b[$];
    int         byte_cyc[$];
    int         got_cv[$], got_co[$], got_cc[$];
    int         ferr_n = 0, perr_n = 0, stray_ovf = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_byte_valid) begin
                got_b.push_back(rx_byte);
                byte_cyc.push_back(cyc);
            end
            if (xinlv_valid) begin
                got_cv.push_back(int'(xinlv));
                got_co.push_back(int'(ovf));
                got_cc.push_back(cyc);
            end
            if (ovf && !xinlv_valid) stray_ovf++;
            if (frame_err) ferr_n++;
            if (parse_err) perr_n++;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int val;
        int ovf;
        int idx;   // index of the good byte that triggered it (or the last one before the timeout)
        bit tmo;
    } commit_t;

    commit_t    exp_c[$];
    logic [7:0] exp_b[$];
    int         exp_ferr = 0, exp_perr = 0;
    int         n_good = 0;
    int         m_match = 0;   // number of "BPM" characters matched so far
    int         m_digits[$];
    int         m_last = 0;

    task automatic m_commit(input int idx, input bit tmo);
        int      v;
        commit_t c;
        v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        c.idx = idx;
        c.tmo = tmo;
        c.ovf = (v > OUT_MAX) ? 1 : 0;
        c.val = (v > OUT_MAX) ? OUT_MAX : v;
        m_last = c.val;
        exp_c.push_back(c);
    endtask

    task automatic model_byte(input logic [7:0] b);
        int idx;
        idx = n_good;
        n_good++;
        exp_b.push_back(b);
        case (m_match)
            0: if (b == 8'h42) m_match = 1;
            1: begin
                if (b == 8'h50)      m_match = 2;
                else if (b != 8'h42) begin exp_perr++; m_match = 0; end
            end
            2: begin
                if (b == 8'h4D) begin
                    m_match = 3;
                    m_digits.delete();
                end else begin
                    exp_perr++;
                    m_match = (b == 8'h42) ? 1 : 0;
                end
            end
            default: begin
                if (b >= 8'h30 && b <= 8'h39) begin
                    m_digits.push_back(int'(b) - 48);
                    if (m_digits.size() == MAX_DIGITS) begin
                        m_commit(idx, 1'b0);
                        m_match = 0;
                    end
                end else begin
                    if (m_digits.size() > 0) m_commit(idx, 1'b0);
                    else                     exp_perr++;
                    m_match = (b == 8'h42) ? 1 : 0;
                end
            end
        endcase
    endtask

    task automatic model_bad();
        exp_ferr++;
        m_match = 0;
    endtask

    task automatic model_timeout();
        if (m_match == 3 && m_digits.size() > 0) m_commit(n_good - 1, 1'b1);
        m_match = 0;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive_bit(input logic v);
        data_rx = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) drive_bit(1'b1);
        repeat (gap) drive_bit(1'b1);
        if (stop_ok) model_byte(b);
        else         model_bad();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 0);
    endtask

    task automatic send_rand(input logic [7:0] b);
        send_byte(b, $urandom_range(0, 24) != 0, $urandom_range(0, 2));
    endtask

    task automatic idle_timeout();
        data_rx = 1'b1;
        repeat (TIMEOUT_CYC + 2 * CLK_DIV) @(negedge clk);
        model_timeout();
    endtask

    int rd_b = 0, rd_c = 0;

    task automatic compare_all(input string tag);
        commit_t    c;
        logic [7:0] e;
        int         base;
        check({tag, " byte count"}, got_b.size() - rd_b, exp_b.size());
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            if (rd_b < got_b.size()) check({tag, " byte"}, got_b[rd_b], e);
            rd_b++;
        end
        rd_b = got_b.size();
        check({tag, " commit count"}, got_cv.size() - rd_c, exp_c.size());
        while (exp_c.size() > 0) begin
            c = exp_c.pop_front();
            if (rd_c < got_cv.size()) begin
                base = (c.idx < byte_cyc.size()) ? byte_cyc[c.idx] : -1;
                check({tag, " xinlv"}, got_cv[rd_c], c.val);
                check({tag, " ovf"}, got_co[rd_c], c.ovf);
                check({tag, " commit cycle"}, got_cc[rd_c], base + (c.tmo ? TIMEOUT_CYC + 1 : 1));
            end
            rd_c++;
        end
        rd_c = got_cv.size();
        check({tag, " frame_err total"}, ferr_n, exp_ferr);
        check({tag, " parse_err total"}, perr_n, exp_perr);
        check({tag, " stray ovf"}, stray_ovf, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " xinlv"}, xinlv, 0);
        check({tag, " xinlv_valid"}, xinlv_valid, 0);
        check({tag, " ovf"}, ovf, 0);
        check({tag, " frame_err"}, frame_err, 0);
        check({tag, " parse_err"}, parse_err, 0);
        check({tag, " rx_byte"}, rx_byte, 0);
        check({tag, " rx_byte_valid"}, rx_byte_valid, 0);
    endtask

    logic [7:0] alpha [8];

    initial begin
        int n;
        alpha = '{8'h42, 8'h50, 8'h4D, 8'h30, 8'h39, 8'h58, 8'h0A, 8'h20};

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back frames: byte-triggered commit then timeout commit
        send_str("BPM69BPM58");
        idle_timeout();
        compare_all("t1");
        check("t1 xinlv hold", xinlv, 58);

        // Max-digit commit, trailing 'B' adds nothing
        send_str("BPM123B");
        idle_timeout();
        compare_all("t2");
        check("t2 xinlv hold", xinlv, 123);

        // Saturation, then a normal value
        send_str("BPM300");
        send_str("BPM87");
        idle_timeout();
        compare_all("t3");
        check("t3 xinlv hold", xinlv, 87);

        // Framing error inside "BPM" leaves the parser idle
        send_str("BP");
        send_byte(8'h4D, 1'b0, 0);
        send_str("M5");
        send_str("BPM75");
        idle_timeout();
        compare_all("t4");
        check("t4 xinlv hold", xinlv, 75);

        // Parse errors, GOT_B re-entry, start-bit glitch
        send_str("BPX");
        send_str("BPMB");
        send_str("PM42");
        idle_timeout();
        @(negedge clk) data_rx = 1'b0;
        repeat (2) @(negedge clk);
        data_rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        compare_all("t5");
        check("t5 xinlv hold", xinlv, 42);

        // Single digit by timeout, then reset mid-byte
        send_str("BPM7");
        idle_timeout();
        compare_all("t6");
        check("t6 xinlv", xinlv, 7);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        data_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        m_match = 0;
        m_digits.delete();
        repeat (4) @(negedge clk);
        send_str("BPM64");
        idle_timeout();
        compare_all("t6b");
        check("t6b xinlv", xinlv, 64);

        // Randomized token stream
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                send_rand(8'h42);
                send_rand(8'h50);
                send_rand(8'h4D);
                n = $urandom_range(1, MAX_DIGITS + 1);
                for (int d = 0; d < n; d++) send_rand(8'h30 + 8'($urandom_range(0, 9)));
            end else begin
                send_rand(alpha[$urandom_range(0, 7)]);
            end
            if ($urandom_range(0, 3) == 0) idle_timeout();
        end
        idle_timeout();
        compare_all("random");
        check("random xinlv hold", xinlv, m_last);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
